trivium_byte_xor: RTL and testbench

TRIVIUM_BYTE_XOR -- requirements
Module: trivium_byte_xor

---
 rtl/trivium_byte_xor_pkg.sv | 20 ++
 rtl/trivium_byte_xor_packer.sv | 62 ++++++
 rtl/trivium_byte_xor.sv | 106 ++++++++++
 tb/tb_trivium_byte_xor.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trivium_byte_xor_pkg.sv
// Shared definitions for the Trivium byte-XOR stream cipher front end:
// FSM encoding, datapath widths and the keystream bit placement helper.
package trivium_byte_xor_pkg;

    localparam int KEY_BYTE_W = 8;
    localparam int BYTE_CNT_W = 16;
    localparam int FILL_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_FILL = 2'd1,
        ST_KEY  = 2'd2
    } state_t;

    // Key bit position for the idx-th collected keystream bit.
    function automatic logic [2:0] bit_pos(input logic lsb_first, input logic [2:0] idx);
        return lsb_first ? idx : 3'd7 - idx;
    endfunction

endpackage

// File: rtl/trivium_byte_xor_packer.sv
// Collects eight registered keystream bits into a key byte. The generator output
// lags its enable by one edge, so captures are qualified by a delayed enable.
module keystream_packer
    import trivium_byte_xor_pkg::*;
#(
    parameter int LSB_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  ks_en,
    input  logic                  ks_ready,
    input  logic                  ks_bit,
    output logic                  issue_full,
    output logic                  fill_done,
    output logic [KEY_BYTE_W-1:0] key
);

    logic [FILL_CNT_W-1:0] issue_cnt_reg;
    logic [FILL_CNT_W-1:0] collect_cnt_reg;
    logic                  cap_d_reg;
    logic [KEY_BYTE_W-1:0] key_reg;
    logic [KEY_BYTE_W-1:0] key_we;
    logic                  store;
    logic [2:0]            pos;

    // Once eight bits are held the byte is frozen until the next clear.
    assign store      = cap_d_reg && !clear && (collect_cnt_reg < FILL_CNT_W'(8));
    assign pos        = bit_pos(LSB_FIRST != 0, collect_cnt_reg[2:0]);
    assign issue_full = (issue_cnt_reg >= FILL_CNT_W'(8));
    assign fill_done  = store && (collect_cnt_reg == FILL_CNT_W'(7));
    assign key        = key_reg;

    generate
        for (genvar gi = 0; gi < KEY_BYTE_W; gi++) begin : g_key_we
            assign key_we[gi] = store && (pos == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_reg   <= '0;
            collect_cnt_reg <= '0;
            cap_d_reg       <= 1'b0;
            key_reg         <= '0;
        end else begin
            cap_d_reg <= ks_en & ks_ready;
            if (clear) begin
                issue_cnt_reg <= '0;
            end else if (ks_en && ks_ready && !issue_full) begin
                issue_cnt_reg <= issue_cnt_reg + FILL_CNT_W'(1);
            end
            if (clear) begin
                collect_cnt_reg <= '0;
            end else if (store) begin
                collect_cnt_reg <= collect_cnt_reg + FILL_CNT_W'(1);
            end
            key_reg <= (key_reg & ~key_we) | ({KEY_BYTE_W{ks_bit}} & key_we);
        end
    end

endmodule

// File: rtl/trivium_byte_xor.sv
// Encrypts plaintext bytes by XOR with one fresh Trivium key byte each; the key
// byte is consumed by exactly one plaintext handshake and never reused.
module trivium_byte_xor
    import trivium_byte_xor_pkg::*;
#(
    parameter int LSB_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ks_bit,
    input  logic                  ks_ready,
    output logic                  ks_en,
    input  logic [KEY_BYTE_W-1:0] pt_data,
    input  logic                  pt_valid,
    output logic                  pt_ready,
    output logic [KEY_BYTE_W-1:0] ct_data,
    output logic                  ct_valid,
    input  logic                  ct_ready,
    output logic [BYTE_CNT_W-1:0] byte_cnt
);

    state_t                state_reg, state_next;
    logic [KEY_BYTE_W-1:0] ct_data_reg;
    logic                  ct_valid_reg;
    logic [BYTE_CNT_W-1:0] byte_cnt_reg;
    logic [KEY_BYTE_W-1:0] key;
    logic                  clear;
    logic                  issue_full;
    logic                  fill_done;
    logic                  pt_hs;
    logic                  ct_hs;

    assign pt_ready = !rst && (state_reg == ST_KEY) && (!ct_valid_reg || ct_ready);
    assign pt_hs    = pt_valid && pt_ready;
    assign ct_hs    = ct_valid_reg && ct_ready;
    assign ct_data  = ct_data_reg;
    assign ct_valid = ct_valid_reg;
    assign byte_cnt = byte_cnt_reg;

    keystream_packer #(
        .LSB_FIRST(LSB_FIRST)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .ks_en     (ks_en),
        .ks_ready  (ks_ready),
        .ks_bit    (ks_bit),
        .issue_full(issue_full),
        .fill_done (fill_done),
        .key       (key)
    );

    always_comb begin
        state_next = state_reg;
        ks_en      = 1'b0;
        clear      = 1'b0;
        case (state_reg)
            ST_INIT: begin
                ks_en = !rst;
                clear = 1'b1;
                if (ks_ready) state_next = ST_FILL;
            end
            ST_FILL: begin
                ks_en = !rst && !issue_full;
                if (!ks_ready) begin
                    state_next = ST_INIT;
                    clear      = 1'b1;
                end else if (fill_done) begin
                    state_next = ST_KEY;
                end
            end
            ST_KEY: begin
                // A handshake still consumes the frozen key even if the generator
                // drops ready on the same edge; FILL then falls back to INIT.
                if (pt_hs) begin
                    state_next = ST_FILL;
                    clear      = 1'b1;
                end else if (!ks_ready) begin
                    state_next = ST_INIT;
                    clear      = 1'b1;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_INIT;
            ct_data_reg  <= '0;
            ct_valid_reg <= 1'b0;
            byte_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (pt_hs) begin
                ct_data_reg  <= pt_data ^ key;
                ct_valid_reg <= 1'b1;
            end else if (ct_hs) begin
                ct_valid_reg <= 1'b0;
            end
            if (ct_hs) byte_cnt_reg <= byte_cnt_reg + BYTE_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_trivium_byte_xor.sv
// Scoreboard bench: a keystream generator stub feeds two instances (LSB-first and
// MSB-first packing); expected ciphertext comes from a bit-stream model.
`timescale 1ns/1ps
module tb_trivium_byte_xor;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       ks_bit;
    logic       ks_ready;
    logic [7:0] pt_data;
    logic       pt_valid;
    logic       ct_ready;

    logic        ks_en_l, pt_ready_l, ct_valid_l;
    logic [7:0]  ct_data_l;
    logic [15:0] byte_cnt_l;
    logic        ks_en_m, pt_ready_m, ct_valid_m;
    logic [7:0]  ct_data_m;
    logic [15:0] byte_cnt_m;

    trivium_byte_xor #(.LSB_FIRST(1)) dut_lsb (
        .clk(clk), .rst(rst), .ks_bit(ks_bit), .ks_ready(ks_ready), .ks_en(ks_en_l),
        .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready_l),
        .ct_data(ct_data_l), .ct_valid(ct_valid_l), .ct_ready(ct_ready),
        .byte_cnt(byte_cnt_l)
    );

    trivium_byte_xor #(.LSB_FIRST(0)) dut_msb (
        .clk(clk), .rst(rst), .ks_bit(ks_bit), .ks_ready(ks_ready), .ks_en(ks_en_m),
        .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready_m),
        .ct_data(ct_data_m), .ct_valid(ct_valid_m), .ct_ready(ct_ready),
        .byte_cnt(byte_cnt_m)
    );

    // Generator stub: ready after ready_delay cycles, then one stream bit per enabled step.
    logic bitseq [0:2047];
    int   ready_delay;
    logic gen_drop;
    int   gen_cyc;
    int   gen_step;

    always @(posedge clk) begin
        if (rst || gen_drop) begin
            gen_cyc  <= 0;
            gen_step <= 0;
            ks_ready <= 1'b0;
            ks_bit   <= 1'b0;
        end else begin
            if (gen_cyc < ready_delay) gen_cyc <= gen_cyc + 1;
            ks_ready <= (gen_cyc + 1 >= ready_delay);
            if (ks_en_l && ks_ready) begin
                ks_bit   <= bitseq[gen_step % 2048];
                gen_step <= gen_step + 1;
            end
        end
    end

    typedef struct packed {
        logic [7:0] l;
        logic [7:0] m;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         byte_idx = 0;
    int         pt_hs_cnt = 0;
    int         ct_hs_cnt = 0;
    int         cyc = 0;
    int         ready_rise_cyc = -1;
    int         first_hs_cyc = -1;
    logic [7:0] last_ct_l = 8'h00;
    logic [7:0] last_ct_m = 8'h00;

    // Stream rule: after warm-up the first key byte is stream bits 0..7; one bit
    // issued while that byte completes is never collected, so byte b>0 starts at 8b+1.
    function automatic exp_t model(input int b, input logic [7:0] pt);
        exp_t e;
        int   start;
        start = (b == 0) ? 0 : 8 * b + 1;
        e.l = pt;
        e.m = pt;
        for (int i = 0; i < 8; i++) begin
            e.l[i]     = e.l[i] ^ bitseq[(start + i) % 2048];
            e.m[7 - i] = e.m[7 - i] ^ bitseq[(start + i) % 2048];
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Stimulus side: push the expected ciphertext whenever a plaintext byte is accepted.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
                byte_idx       = 0;
                cyc            = 0;
                ready_rise_cyc = -1;
                first_hs_cyc   = -1;
            end else begin
                cyc++;
                if (ks_ready && ready_rise_cyc < 0) ready_rise_cyc = cyc;
                if (pt_valid && pt_ready_l) begin
                    sb_q.push_back(model(byte_idx, pt_data));
                    byte_idx++;
                    pt_hs_cnt++;
                    if (first_hs_cyc < 0) first_hs_cyc = cyc;
                end
                if (!ks_ready) byte_idx = 0;
            end
        end
    end

    // Monitor: pop and compare on every ciphertext handshake; check hold stability.
    initial begin
        logic       hold_prev;
        logic [7:0] prev_data;
        exp_t       e;
        hold_prev = 1'b0;
        prev_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
                ct_hs_cnt = 0;
            end else begin
                if (hold_prev) begin
                    check("ct_hold_valid", 32'(ct_valid_l), 32'd1);
                    check("ct_hold_data", 32'(ct_data_l), 32'(prev_data));
                end
                if (ct_valid_l && ct_ready) begin
                    if (sb_q.size() == 0) begin
                        timeout("ct_unexpected_byte");
                    end else begin
                        e = sb_q.pop_front();
                        check("ct_data_lsb", 32'(ct_data_l), 32'(e.l));
                        check("ct_valid_msb", 32'(ct_valid_m), 32'd1);
                        check("ct_data_msb", 32'(ct_data_m), 32'(e.m));
                        last_ct_l = ct_data_l;
                        last_ct_m = ct_data_m;
                        ct_hs_cnt++;
                        $display("ct byte %0d: lsb=0x%02h msb=0x%02h", ct_hs_cnt, ct_data_l, ct_data_m);
                    end
                end
                hold_prev = ct_valid_l && !ct_ready;
                prev_data = ct_data_l;
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input int budget, input string name);
        int target;
        bit done;
        target   = pt_hs_cnt + 1;
        done     = 1'b0;
        pt_data  = d;
        pt_valid = 1'b1;
        for (int n = 0; n < budget && !done; n++) begin
            @(posedge clk);
            #2;
            if (pt_hs_cnt >= target) done = 1'b1;
        end
        pt_valid = 1'b0;
        if (!done) timeout(name);
    endtask

    task automatic wait_drain(input int budget, input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(posedge clk);
            #2;
            if (sb_q.size() == 0 && !ct_valid_l) done = 1'b1;
        end
        if (!done) timeout(name);
    endtask

    initial begin
        int h0;
        int last_hs;
        bit done;
        rst         = 1'b1;
        gen_drop    = 1'b0;
        ready_delay = 5;
        pt_data     = 8'h00;
        pt_valid    = 1'b0;
        ct_ready    = 1'b1;
        for (int i = 0; i < 2048; i++) bitseq[i] = 1'($urandom);
        bitseq[0] = 1'b1; bitseq[1] = 1'b0; bitseq[2] = 1'b1; bitseq[3] = 1'b1;
        bitseq[4] = 1'b0; bitseq[5] = 1'b0; bitseq[6] = 1'b1; bitseq[7] = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ks_en", 32'(ks_en_l), 32'd0);
        check("rst_pt_ready", 32'(pt_ready_l), 32'd0);
        check("rst_ct_valid", 32'(ct_valid_l), 32'd0);
        check("rst_ct_data", 32'(ct_data_l), 32'h00);
        check("rst_byte_cnt", 32'(byte_cnt_l), 32'd0);

        // Known stub sequence, plaintext 0x00.
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        check("init_ks_en", 32'(ks_en_l), 32'd1);
        send_byte(8'h00, 100, "pt_A_timeout");
        wait_drain(50, "ct_A_timeout");
        check("ct_A_lsb_4D", 32'(last_ct_l), 32'h4D);
        check("ct_A_msb_B2", 32'(last_ct_m), 32'hB2);
        check("byte_cnt_A", 32'(byte_cnt_l), 32'd1);

        // Same sequence, plaintext 0xFF.
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        send_byte(8'hFF, 100, "pt_B_timeout");
        wait_drain(50, "ct_B_timeout");
        check("ct_B_lsb_B2", 32'(last_ct_l), 32'hB2);
        check("ct_B_msb_4D", 32'(last_ct_m), 32'h4D);

        // Consumer stalled for 24 cycles with plaintext always offered.
        ct_ready = 1'b0;
        h0       = pt_hs_cnt;
        pt_data  = 8'($urandom);
        pt_valid = 1'b1;
        repeat (24) @(posedge clk);
        #2;
        check("stall_pt_hs_count", 32'(pt_hs_cnt - h0), 32'd1);
        check("stall_pt_ready", 32'(pt_ready_l), 32'd0);
        check("stall_ct_valid", 32'(ct_valid_l), 32'd1);
        ct_ready = 1'b1;
        send_byte(8'($urandom), 100, "pt_C1_timeout");
        send_byte(8'($urandom), 100, "pt_C2_timeout");
        wait_drain(50, "ct_C_timeout");
        check("byte_cnt_C", 32'(byte_cnt_l), 32'd4);

        // ks_ready drops after three bits of the next key byte.
        send_byte(8'($urandom), 100, "pt_D0_timeout");
        repeat (3) @(posedge clk);
        #2 gen_drop = 1'b1;
        @(posedge clk); #2 gen_drop = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("drop_ks_en_init", 32'(ks_en_l), 32'd1);
        check("drop_pt_ready", 32'(pt_ready_l), 32'd0);
        send_byte(8'h00, 100, "pt_D1_timeout");
        wait_drain(50, "ct_D_timeout");
        check("ct_D_fresh_4D", 32'(last_ct_l), 32'h4D);

        // Reset while a ciphertext byte is pending.
        ct_ready = 1'b0;
        send_byte(8'($urandom), 100, "pt_E_timeout");
        check("pre_rst_ct_valid", 32'(ct_valid_l), 32'd1);
        rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ct_valid", 32'(ct_valid_l), 32'd0);
        check("post_rst_byte_cnt", 32'(byte_cnt_l), 32'd0);
        check("post_rst_ks_en", 32'(ks_en_l), 32'd1);

        // Long warm-up, then 64 random bytes under random flow control.
        @(posedge clk); #2 rst = 1'b1;
        ready_delay = 1152;
        for (int i = 0; i < 2048; i++) bitseq[i] = 1'($urandom);
        ct_ready = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        h0       = pt_hs_cnt;
        last_hs  = pt_hs_cnt;
        pt_data  = 8'($urandom);
        pt_valid = 1'b1;
        done     = 1'b0;
        for (int n = 0; n < 20000 && !done; n++) begin
            @(posedge clk);
            #2;
            if (pt_hs_cnt != last_hs) begin
                last_hs  = pt_hs_cnt;
                pt_data  = 8'($urandom);
                pt_valid = ($urandom % 4) != 0;
            end else if (!pt_valid) begin
                pt_valid = ($urandom % 4) != 0;
            end
            if (pt_hs_cnt - h0 > 0) ct_ready = ($urandom % 4) != 0;
            if (pt_hs_cnt - h0 >= 64) done = 1'b1;
        end
        pt_valid = 1'b0;
        ct_ready = 1'b1;
        if (!done) timeout("rand_pt_timeout");
        wait_drain(100, "rand_drain_timeout");
        check("rand_ready_latency_ok", 32'(first_hs_cyc - ready_rise_cyc >= 9), 32'd1);
        check("rand_first_hs_after_1161", 32'(first_hs_cyc >= 1161), 32'd1);
        check("rand_pt_count", 32'(pt_hs_cnt - h0), 32'd64);
        check("rand_byte_cnt", 32'(byte_cnt_l), 32'd64);
        check("rand_byte_cnt_msb", 32'(byte_cnt_m), 32'd64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
